// File: rtl/ieee754_normalize_pipe.sv
// ieee754_normalize_pipe
//
// Purpose: pipelined leading-zero normaliser for a floating-point significand.
// A SHIFT_W-layer logarithmic left shifter (largest shift first) is spread over
// STAGES register stages. The final stage strips the leading one, adjusts the
// exponent and raises the zero / underflow / sticky flags. An opaque tag rides
// along with every beat.
//
// Optional feature: define IEEE754_NORMALIZE_STICKY_EN to drive out_sticky with
// the bit discarded when the hidden one is removed. When the macro is undefined,
// out_sticky is tied low and no sticky logic exists.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   in_valid / in_ready    input handshake
//   in_src  [WIDTH]        unnormalised significand (bit WIDTH-1 = carry position)
//   in_exp  [EXP_W]        exponent of in_src
//   in_tag  [TAG_W]        sideband tag, returned unchanged
//   out_valid / out_ready  output handshake
//   out_result [WIDTH-2]   normalised fraction, hidden one removed
//   out_shift  [SHIFT_W]   left-shift amount applied (leading-zero count)
//   out_exp    [EXP_W]     adjusted exponent
//   out_zero, out_uflow, out_sticky   result flags
//   out_tag    [TAG_W]     tag of the beat
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. A producer holding valid keeps its payload stable until it transfers;
// ready may depend combinationally on the downstream ready (in_ready does).
module ieee754_normalize_pipe #(
    parameter int WIDTH   = 25,
    parameter int SHIFT_W = $clog2(WIDTH),
    parameter int EXP_W   = 8,
    parameter int STAGES  = 2,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_src,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-3:0]   out_result,
    output logic [SHIFT_W-1:0] out_shift,
    output logic [EXP_W-1:0]   out_exp,
    output logic               out_zero,
    output logic               out_uflow,
    output logic               out_sticky,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int LAYERS_PER_STAGE = (SHIFT_W + STAGES - 1) / STAGES;
    // Wide enough that in_exp + 1 never wraps and can be compared with the shift.
    localparam int EW = ((EXP_W > SHIFT_W) ? EXP_W : SHIFT_W) + 2;
    localparam logic [SHIFT_W-1:0] ZERO_SHIFT = SHIFT_W'(WIDTH - 1);

    // w_en[s]: stage s may load this cycle (empty, or its content moves on).
    // w_en[STAGES] is the downstream consumer.
    logic               w_en       [STAGES+1];
    // Inputs seen by stage s: the module inputs for stage 0, else stage s-1 regs.
    logic               w_in_vld   [STAGES];
    logic [WIDTH-1:0]   w_in_word  [STAGES];
    logic [SHIFT_W-1:0] w_in_shift [STAGES];
    logic [EXP_W-1:0]   w_in_exp   [STAGES];
    logic [TAG_W-1:0]   w_in_tag   [STAGES];

    // Final-stage output registers.
    logic [WIDTH-3:0]   r_result;
    logic [SHIFT_W-1:0] r_shift;
    logic [EXP_W-1:0]   r_exp;
    logic               r_zero;
    logic               r_uflow;
    logic [TAG_W-1:0]   r_tag;
`ifdef IEEE754_NORMALIZE_STICKY_EN
    logic               r_sticky;
`endif

    assign w_en[STAGES]  = out_ready;
    assign in_ready      = w_en[0];

    assign w_in_vld[0]   = in_valid;
    assign w_in_word[0]  = in_src;
    assign w_in_shift[0] = '0;
    assign w_in_exp[0]   = in_exp;
    assign w_in_tag[0]   = in_tag;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        // Layer range [LO, HI) handled by this stage; the last stage may get fewer.
        localparam int LO = s * LAYERS_PER_STAGE;
        localparam int HI = ((s + 1) * LAYERS_PER_STAGE < SHIFT_W) ?
                            (s + 1) * LAYERS_PER_STAGE : SHIFT_W;

        logic               r_vld;
        logic [WIDTH-1:0]   w_word;
        logic [SHIFT_W-1:0] w_shift;

        assign w_en[s] = !r_vld || w_en[s+1];

        // Layer k shifts by 2^(SHIFT_W-1-k) when that many top bits are zero.
        always_comb begin
            w_word  = w_in_word[s];
            w_shift = w_in_shift[s];
            for (int k = LO; k < HI; k++) begin
                if ((w_word & ~({WIDTH{1'b1}} >> (1 << (SHIFT_W - 1 - k)))) == '0) begin
                    w_word  = w_word << (1 << (SHIFT_W - 1 - k));
                    w_shift = w_shift | SHIFT_W'(1 << (SHIFT_W - 1 - k));
                end
            end
        end

        if (s < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0]   r_word;
            logic [SHIFT_W-1:0] r_shift_acc;
            logic [EXP_W-1:0]   r_exp_in;
            logic [TAG_W-1:0]   r_tag_in;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_vld       <= 1'b0;
                    r_word      <= '0;
                    r_shift_acc <= '0;
                    r_exp_in    <= '0;
                    r_tag_in    <= '0;
                end else if (w_en[s]) begin
                    r_vld <= w_in_vld[s];
                    if (w_in_vld[s]) begin
                        r_word      <= w_word;
                        r_shift_acc <= w_shift;
                        r_exp_in    <= w_in_exp[s];
                        r_tag_in    <= w_in_tag[s];
                    end
                end
            end

            assign w_in_vld[s+1]   = r_vld;
            assign w_in_word[s+1]  = r_word;
            assign w_in_shift[s+1] = r_shift_acc;
            assign w_in_exp[s+1]   = r_exp_in;
            assign w_in_tag[s+1]   = r_tag_in;
        end else begin : g_last
            logic               w_zero;
            logic               w_uflow;
            logic [WIDTH-3:0]   w_result;
            logic [SHIFT_W-1:0] w_fshift;
            logic [EXP_W-1:0]   w_fexp;

            always_comb begin
                w_zero   = (w_word == '0);
                w_uflow  = 1'b0;
                w_fshift = w_shift;
                // Low EXP_W bits of in_exp + 1 - shift; wrap-around is intended.
                w_fexp   = w_in_exp[s] + EXP_W'(1) - EXP_W'(w_shift);
                if (w_word[WIDTH-1]) begin
                    w_result = w_word[WIDTH-2:1];
                end else begin
                    w_result = w_word[WIDTH-3:0];
                end
                if (w_zero) begin
                    // The shifter saturates at all ones; a zero input reports WIDTH-1.
                    w_result = '0;
                    w_fshift = ZERO_SHIFT;
                    w_fexp   = '0;
                end else if (EW'(w_in_exp[s]) + EW'(1) <= EW'(w_shift)) begin
                    // Exponent would be zero or negative.
                    w_uflow = 1'b1;
                    w_fexp  = '0;
                end
            end

`ifdef IEEE754_NORMALIZE_STICKY_EN
            // Bit dropped when the result is taken from word[WIDTH-2:1].
            logic w_sticky;
            assign w_sticky = w_word[WIDTH-1] & w_word[0];
`endif

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_vld    <= 1'b0;
                    r_result <= '0;
                    r_shift  <= '0;
                    r_exp    <= '0;
                    r_zero   <= 1'b0;
                    r_uflow  <= 1'b0;
                    r_tag    <= '0;
`ifdef IEEE754_NORMALIZE_STICKY_EN
                    r_sticky <= 1'b0;
`endif
                end else if (w_en[s]) begin
                    r_vld <= w_in_vld[s];
                    if (w_in_vld[s]) begin
                        r_result <= w_result;
                        r_shift  <= w_fshift;
                        r_exp    <= w_fexp;
                        r_zero   <= w_zero;
                        r_uflow  <= w_uflow;
                        r_tag    <= w_in_tag[s];
`ifdef IEEE754_NORMALIZE_STICKY_EN
                        r_sticky <= w_sticky;
`endif
                    end
                end
            end

            assign out_valid = r_vld;
        end
    end

    assign out_result = r_result;
    assign out_shift  = r_shift;
    assign out_exp    = r_exp;
    assign out_zero   = r_zero;
    assign out_uflow  = r_uflow;
    assign out_tag    = r_tag;
`ifdef IEEE754_NORMALIZE_STICKY_EN
    assign out_sticky = r_sticky;
`else
    assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_ieee754_normalize_pipe.sv
// Testbench for ieee754_normalize_pipe with default parameters
// (WIDTH=25, EXP_W=8, STAGES=2, TAG_W=4). Beats are packed as
// {result, shift, exp, zero, uflow, sticky, tag} for comparison.
module tb_ieee754_normalize_pipe;

    localparam int RW = 23 + 5 + 8 + 3 + 4;

`ifdef IEEE754_NORMALIZE_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] in_src = '0;
    logic [7:0]  in_exp = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [22:0] out_result;
    logic [4:0]  out_shift;
    logic [7:0]  out_exp;
    logic        out_zero;
    logic        out_uflow;
    logic        out_sticky;
    logic [3:0]  out_tag;

    always #5 clk = ~clk;

    ieee754_normalize_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_src    (in_src),
        .in_exp    (in_exp),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_shift (out_shift),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_uflow (out_uflow),
        .out_sticky(out_sticky),
        .out_tag   (out_tag)
    );

    logic [RW-1:0] obs;
    assign obs = {out_result, out_shift, out_exp, out_zero, out_uflow, out_sticky, out_tag};

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    // Count leading zeros, normalise so the leading one sits at the carry
    // position, drop it, and derive the exponent with integer arithmetic.
    function automatic logic [RW-1:0] model(input logic [24:0] src,
                                            input logic [7:0] e_in,
                                            input logic [3:0] tag);
        logic [24:0] w;
        int          lz;
        int          ev;
        logic [22:0] res;
        logic [4:0]  sh;
        logic [7:0]  eo;
        logic        z;
        logic        u;
        logic        st;
        if (src == '0) begin
            z = 1'b1; u = 1'b0; st = 1'b0; res = '0; sh = 5'd24; eo = '0;
        end else begin
            w  = src;
            lz = 0;
            while (!w[24]) begin
                w  = w << 1;
                lz = lz + 1;
            end
            z   = 1'b0;
            sh  = 5'(lz);
            res = 23'(w >> 1);
            st  = STICKY_ON & w[0];
            ev  = int'(e_in) + 1 - lz;
            if (ev <= 0) begin
                u  = 1'b1;
                eo = '0;
            end else begin
                u  = 1'b0;
                eo = 8'(ev % 256);
            end
        end
        return {res, sh, eo, z, u, st, tag};
    endfunction

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_beat;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL scoreboard_extra_beat: got %h, expected no beat", obs);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if (obs !== exp_beat) begin
                        n_errors++;
                        $display("FAIL scoreboard_beat: got %h, expected %h", obs, exp_beat);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_src, in_exp, in_tag));
        end
    end

    // ---------------- driver ----------------
    // Presents one beat, holds it until accepted, returns at posedge+1 of the
    // cycle after the accepting one.
    task automatic send_one(input logic [24:0] src, input logic [7:0] e_in,
                            input logic [3:0] tag, output int waited);
        @(posedge clk); #1;
        in_valid = 1'b1; in_src = src; in_exp = e_in; in_tag = tag;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        n_checks++;
        if (obs !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h, expected 0", obs);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [24:0] d_src [10] = '{25'h1000001, 25'h0800000, 25'h0000001, 25'h0000003, 25'h0000000,
                                    25'h1FFFFFF, 25'h0000001, 25'h0000001, 25'h0000002, 25'h1234567};
        logic [7:0]  d_exp [10] = '{8'd100, 8'd100, 8'd100, 8'd10, 8'd55,
                                    8'd255, 8'd23, 8'd24, 8'd200, 8'd0};
        logic [4:0]  d_sh  [10] = '{5'd0, 5'd1, 5'd24, 5'd23, 5'd24, 5'd0, 5'd24, 5'd24, 5'd23, 5'd0};
        logic [22:0] d_res [10] = '{23'h0, 23'h0, 23'h0, 23'h400000, 23'h0,
                                    23'h7FFFFF, 23'h0, 23'h0, 23'h0, 23'h11A2B3};
        logic [7:0]  d_eo  [10] = '{8'd101, 8'd100, 8'd77, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd178, 8'd1};
        logic        d_z   [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        logic        d_u   [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
        logic        d_st  [10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 1};
        logic [RW-1:0] want;
        int waited;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_one(d_src[i], d_exp[i], 4'(i), waited);
            if (waited >= 50) begin
                n_checks++; n_errors++;
                $display("FAIL directed_accept_%0d: in_ready stayed low %0d cycles", i, waited);
            end
            lat = 1;
            @(negedge clk);
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            n_checks++;
            if (lat != 2) begin
                n_errors++;
                $display("FAIL directed_latency_%0d: got %0d cycles, expected 2", i, lat);
            end
            want = {d_res[i], d_sh[i], d_eo[i], d_z[i], d_u[i], d_st[i] & STICKY_ON, 4'(i)};
            n_checks++;
            if (obs !== want) begin
                n_errors++;
                $display("FAIL directed_value_%0d: got %h, expected %h", i, obs, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  first = -1;
        int  last = -1;
        int  got = 0;
        bit  rdy_ok = 1'b1;
        bit  gap_ok = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            in_valid = (c < 8);
            if (c < 8) begin
                in_src = 25'($urandom) >> $urandom_range(0, 25);
                in_exp = 8'($urandom);
                in_tag = 4'(c);
            end
            @(negedge clk);
            if (c < 8 && !in_ready) rdy_ok = 1'b0;
            if (out_valid) begin
                if (first < 0) first = c;
                else if (c != last + 1) gap_ok = 1'b0;
                last = c;
                got++;
            end
        end
        n_checks++;
        if (!rdy_ok) begin
            n_errors++;
            $display("FAIL b2b_in_ready: in_ready dropped during stream, expected always 1");
        end
        n_checks++;
        if (first != 2) begin
            n_errors++;
            $display("FAIL b2b_first_latency: got cycle %0d, expected 2", first);
        end
        n_checks++;
        if (got != 8 || !gap_ok) begin
            n_errors++;
            $display("FAIL b2b_throughput: got %0d beats gapless=%0b, expected 8 gapless", got, gap_ok);
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int recv = 0;
        int last_out = -1;
        logic [RW-1:0] held = '0;
        for (int c = 1; c <= 40 && recv < 6; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 2 && c <= 6);
            if (!in_valid || sent > 0) begin
                in_valid = (sent < 6);
                in_tag   = 4'(sent + 1);
            end
            if (in_valid && in_tag == 4'(sent + 1) && (c == 1 || sent > 0)) begin
                // new payload only for a beat not yet presented
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                in_src = 25'($urandom) >> $urandom_range(0, 25);
                in_exp = 8'($urandom);
            end
            if (c >= 3 && c <= 6) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL bp_in_ready_c%0d: got %b, expected 0", c, in_ready);
                end
            end
            if (c == 3) begin
                held = obs;
                n_checks++;
                if (out_valid !== 1'b1 || out_tag !== 4'd1) begin
                    n_errors++;
                    $display("FAIL bp_head: out_valid=%b tag=%0d, expected 1 1", out_valid, out_tag);
                end
            end
            if (c >= 4 && c <= 6) begin
                n_checks++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    n_errors++;
                    $display("FAIL bp_stable_c%0d: got %h valid=%b, expected %h valid=1", c, obs, out_valid, held);
                end
            end
            if (out_valid && out_ready) begin
                recv++;
                if (last_out >= 0) begin
                    n_checks++;
                    if (c != last_out + 1) begin
                        n_errors++;
                        $display("FAIL bp_gap: beat at cycle %0d, expected %0d", c, last_out + 1);
                    end
                end
                last_out = c;
                n_checks++;
                if (out_tag !== 4'(recv)) begin
                    n_errors++;
                    $display("FAIL bp_order: got tag %0d, expected %0d", out_tag, recv);
                end
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (recv != 6 || sent != 6) begin
            n_errors++;
            $display("FAIL bp_count: got %0d out %0d in, expected 6 6", recv, sent);
        end
    endtask

    task automatic test_random();
        bit pending = 1'b0;
        int waited = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pending) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_src   = 25'($urandom) >> $urandom_range(0, 25);
                in_exp   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
                in_tag   = 4'($urandom);
            end
            @(negedge clk);
            pending = in_valid && !in_ready;
        end
        while (pending && waited < 50) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            pending = in_valid && !in_ready;
            waited++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL random_drain: %0d beats outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        bit leaked = 1'b0;
        int waited;
        int lat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_src = 25'h0123456; in_exp = 8'd90; in_tag = 4'hA;
        @(posedge clk); #1;
        in_src = 25'h1ABCDEF; in_tag = 4'hB;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_inflight: out_valid=%b, expected 1 before reset", out_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_async: out_valid=%b, expected 0 right after reset", out_valid);
        end
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid) leaked = 1'b1;
        end
        n_checks++;
        if (leaked) begin
            n_errors++;
            $display("FAIL midreset_leak: out_valid=1 after reset, expected no beat");
        end
        send_one(25'h0004321, 8'd40, 4'h5, waited);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 2 || waited != 0) begin
            n_errors++;
            $display("FAIL midreset_next_latency: got %0d (accept wait %0d), expected 2 (0)", lat, waited);
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ieee754_normalize_pipe.md
IEEE754_NORMALIZE_PIPE -- requirements
Module: ieee754_normalize_pipe

Interface
REQ-001 Parameter WIDTH, default 25, SHALL be the significand input width; legal range 4..64.
REQ-002 Parameter SHIFT_W, default $clog2(WIDTH), SHALL be the shift-count width.
REQ-003 Parameter EXP_W, default 8, SHALL be the unsigned exponent width.
REQ-004 Parameter STAGES, default 2, SHALL be the register-stage count; legal range 1..SHIFT_W.
REQ-005 Parameter TAG_W, default 4, SHALL be the width of the pass-through sideband tag.
REQ-006 clk  input  1  SHALL be the clock; all state is updated on its rising edge.
REQ-007 reset  input  1  SHALL be the reset, asynchronous and active-high.
REQ-008 in_valid  input  1  SHALL mark the input beat as valid.
REQ-009 in_ready  output  1  SHALL accept the input beat when high together with in_valid.
REQ-010 in_src  input  WIDTH  SHALL carry the unnormalised significand; bit WIDTH-1 is the carry position.
REQ-011 in_exp  input  EXP_W  SHALL carry the exponent of in_src.
REQ-012 in_tag  input  TAG_W  SHALL carry an opaque tag returned unchanged with the result.
REQ-013 out_valid  output  1  SHALL mark the output beat as valid.
REQ-014 out_ready  input  1  SHALL consume the output beat when high together with out_valid.
REQ-015 out_result  output  WIDTH-2  SHALL carry the normalised fraction with the hidden one removed.
REQ-016 out_shift  output  SHIFT_W  SHALL carry the left-shift amount applied.
REQ-017 out_exp  output  EXP_W  SHALL carry the adjusted exponent.
REQ-018 out_zero, out_uflow, out_sticky  output  1 each  SHALL carry the zero, underflow and sticky flags.
REQ-019 out_tag  output  TAG_W  SHALL carry the tag of the beat.

Function
REQ-020 Normalisation SHALL be a SHIFT_W-layer log shifter; layer k (MSB first) shifts left by 2^(SHIFT_W-1-k) when the top 2^(SHIFT_W-1-k) bits of the current word are zero, and sets the corresponding out_shift bit.
REQ-021 After the shifter: bit WIDTH-1 set -> out_result = word[WIDTH-2:1]; otherwise -> out_result = word[WIDTH-3:0].
REQ-022 out_shift SHALL equal the number of leading zeros of in_src, saturated to WIDTH-1.
REQ-023 Unrounded exponent value E = in_exp + 1 - out_shift, computed at full precision.
REQ-024 E <= 0 and in_src != 0 -> out_uflow=1 and out_exp=0; otherwise out_uflow=0 and out_exp=E[EXP_W-1:0].
REQ-025 in_src == 0 -> out_zero=1, out_result=0, out_exp=0, out_uflow=0, out_sticky=0, out_shift=WIDTH-1.
REQ-026 Layers SHALL be split across STAGES register stages, ceil(SHIFT_W/STAGES) layers per stage, the last stage taking the remainder; exponent, tag and flag logic travels with its beat.
REQ-027 Latency from input handshake to out_valid SHALL be exactly STAGES cycles when out_ready is held high.
REQ-028 Each stage SHALL hold a valid bit and advance when it is empty or the next stage advances; in_ready = !stage0_valid || stage0_advance (combinational).
REQ-029 Throughput SHALL be one beat per cycle with out_ready high; no bubbles are inserted.
REQ-030 With out_ready low, the pipeline SHALL fill to STAGES beats, then drop in_ready; no beat is lost, duplicated or reordered.
REQ-031 Output fields SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-032 Reset SHALL asynchronously clear all stage valid bits, so out_valid=0 and in_ready=1 on the first edge after release.
REQ-033 Reset SHALL force out_result, out_shift, out_exp, out_tag and all flags to 0.
REQ-034 Reset mid-operation SHALL discard all in-flight beats; no beat issued before reset is ever output.

Configuration
REQ-035 Macro IEEE754_NORMALIZE_STICKY_EN defined -> out_sticky = the bit discarded by REQ-021 (word[0] when bit WIDTH-1 is set, else 0), registered with its beat.
REQ-036 Macro IEEE754_NORMALIZE_STICKY_EN undefined -> out_sticky is tied to 0 and no sticky logic is generated.

Verification (WIDTH=25, EXP_W=8, STAGES=2, out_ready=1 unless stated)
REQ-037 in_src=25'h1000001, in_exp=100 -> out_shift=0, out_result=23'h000000, out_exp=101, out_sticky=1 (with macro) / 0 (without), 2 cycles later.
REQ-038 in_src=25'h0800000, in_exp=100 -> out_shift=1, out_result=0, out_exp=100; in_src=25'h0000001, in_exp=100 -> out_shift=24, out_exp=77.
REQ-039 in_src=25'h0000003, in_exp=10 -> out_shift=23, out_result=23'h400000, out_uflow=1, out_exp=0; in_src=0 -> out_zero=1, out_shift=24.
REQ-040 Stream tags 1..6 back-to-back with out_ready low for cycles 2..6 -> in_ready falls after two beats are held; tags emerge 1..6 in order with no gaps once out_ready rises.
REQ-041 Reset asserted asynchronously mid-cycle with 2 beats in flight -> out_valid falls immediately; neither beat appears after release; the next beat's latency is 2.
